// File: rtl/sample_ascii_fmt_pkg.sv
// Shared types and constants for the ASCII sample formatter: FSM encoding,
// frame geometry and the byte-selection helper used by the output mux.
package sample_ascii_fmt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam int unsigned FRAME_LEN  = 8;
    localparam int unsigned BCD_BITS   = 13;
    localparam int unsigned BCD_DIGITS = 4;
    localparam int unsigned BCD_WIDTH  = 4 * BCD_DIGITS;

    localparam logic [7:0] ASCII_T     = 8'h54;
    localparam logic [7:0] ASCII_L     = 8'h4C;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Frame layout: prefix, ':', four digits (MSD first), CR, LF.
    function automatic logic [7:0] frame_byte(
        input logic [2:0]           idx,
        input logic                 tag,
        input logic [BCD_WIDTH-1:0] bcd
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = tag ? ASCII_L : ASCII_T;
            3'd1:    b = ASCII_COLON;
            3'd2:    b = ASCII_ZERO + {4'h0, bcd[15:12]};
            3'd3:    b = ASCII_ZERO + {4'h0, bcd[11:8]};
            3'd4:    b = ASCII_ZERO + {4'h0, bcd[7:4]};
            3'd5:    b = ASCII_ZERO + {4'h0, bcd[3:0]};
            3'd6:    b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sample_ascii_fmt_if.sv
// Sample-in / byte-out bundle of the ASCII formatter; the formatter sits on
// the slave side, the SPI reader and UART transmitter on the master side.
interface sample_ascii_fmt_if #(
    parameter int unsigned DATA_WIDTH_P = 12
);

    logic [DATA_WIDTH_P-1:0] Sample_i;
    logic                    Sample_valid_i;
    logic                    Temp_LDR_i;
    logic                    Busy_o;
    logic [7:0]              Byte_o;
    logic                    Byte_valid_o;
    logic                    Byte_ready_i;
    logic                    Frame_done_o;
    logic                    Overrun_o;

    modport slave (
        input  Sample_i,
        input  Sample_valid_i,
        input  Temp_LDR_i,
        input  Byte_ready_i,
        output Busy_o,
        output Byte_o,
        output Byte_valid_o,
        output Frame_done_o,
        output Overrun_o
    );

    modport master (
        output Sample_i,
        output Sample_valid_i,
        output Temp_LDR_i,
        output Byte_ready_i,
        input  Busy_o,
        input  Byte_o,
        input  Byte_valid_o,
        input  Frame_done_o,
        input  Overrun_o
    );

endinterface

// File: rtl/sample_ascii_fmt_bin2bcd_seq.sv
// Sequential double-dabble converter: load on start, then one shift per clock
// for BCD_BITS clocks; done flags the edge that performs the final shift.
module bin2bcd_seq
    import sample_ascii_fmt_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BCD_BITS-1:0]  bin,
    output logic                 done,
    output logic [BCD_WIDTH-1:0] bcd
);

    logic [BCD_BITS-1:0]  bin_sh;
    logic [BCD_WIDTH-1:0] bcd_q;
    logic [3:0]           cnt;
    logic                 active;
    logic [11:0]          adj;

    // Thousands digit never needs the +3 step: inputs stay below 10000.
    always_comb begin
        adj = bcd_q[11:0];
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sh <= '0;
            bcd_q  <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            bin_sh <= bin;
            bcd_q  <= '0;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            bcd_q  <= {bcd_q[14:12], adj, bin_sh[BCD_BITS-1]};
            bin_sh <= {bin_sh[BCD_BITS-2:0], 1'b0};
            cnt    <= cnt + 4'd1;
            if (cnt == 4'(BCD_BITS - 1)) begin
                active <= 1'b0;
            end
        end
    end

    assign done = active && (cnt == 4'(BCD_BITS - 1));
    assign bcd  = bcd_q;

endmodule

// File: rtl/sample_ascii_fmt.sv
// Formats a tagged ADC sample as an 8-byte ASCII frame ("T:0043\r\n") and
// streams it over a valid/ready byte interface toward a UART transmitter.
module sample_ascii_fmt
    import sample_ascii_fmt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_P = 12
) (
    input  logic              Clk_i,
    input  logic              Reset_i,
    sample_ascii_fmt_if.slave bus
);

    state_t               state;
    logic                 tag;
    logic [2:0]           byte_idx;
    logic [7:0]           byte_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 overrun_q;
    logic [BCD_BITS-1:0]  bin_ext;
    logic                 conv_start;
    logic                 conv_done;
    logic [BCD_WIDTH-1:0] bcd;

    always_comb begin
        bin_ext                    = '0;
        bin_ext[DATA_WIDTH_P-1:0]  = bus.Sample_i;
    end

    assign conv_start = (state == ST_IDLE) && bus.Sample_valid_i;

    bin2bcd_seq u_bin2bcd (
        .clk   (Clk_i),
        .rst   (Reset_i),
        .start (conv_start),
        .bin   (bin_ext),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // The first byte is the prefix, so it can be loaded on the same edge as
    // the last conversion shift; digits are read only on later transfers.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state     <= ST_IDLE;
            tag       <= 1'b0;
            byte_idx  <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.Sample_valid_i) begin
                        tag    <= bus.Temp_LDR_i;
                        busy_q <= 1'b1;
                        state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (bus.Sample_valid_i) begin
                        overrun_q <= 1'b1;
                    end
                    if (conv_done) begin
                        state    <= ST_SEND;
                        byte_idx <= '0;
                        valid_q  <= 1'b1;
                        byte_q   <= frame_byte(3'd0, tag, bcd);
                    end
                end
                ST_SEND: begin
                    if (bus.Sample_valid_i) begin
                        overrun_q <= 1'b1;
                    end
                    if (valid_q && bus.Byte_ready_i) begin
                        if (byte_idx == 3'(FRAME_LEN - 1)) begin
                            state    <= ST_IDLE;
                            valid_q  <= 1'b0;
                            byte_q   <= '0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            byte_idx <= '0;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            byte_q   <= frame_byte(byte_idx + 3'd1, tag, bcd);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Busy_o       = busy_q;
    assign bus.Byte_o       = byte_q;
    assign bus.Byte_valid_o = valid_q;
    assign bus.Frame_done_o = done_q;
    assign bus.Overrun_o    = overrun_q;

endmodule

// File: tb/tb_sample_ascii_fmt.sv
// Self-checking bench for sample_ascii_fmt: directed and random frames
// compared against a decimal-arithmetic model of the expected ASCII frame.
module tb_sample_ascii_fmt;

    localparam int unsigned DW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    sample_ascii_fmt_if #(.DATA_WIDTH_P(DW)) bus ();

    sample_ascii_fmt #(.DATA_WIDTH_P(DW)) dut (
        .Clk_i   (clk),
        .Reset_i (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_byte(input int v, input bit tag, input int k);
        case (k)
            0:       return tag ? 8'h4C : 8'h54;
            1:       return 8'h3A;
            2:       return 8'(48 + (v / 1000) % 10);
            3:       return 8'(48 + (v / 100) % 10);
            4:       return 8'(48 + (v / 10) % 10);
            5:       return 8'(48 + v % 10);
            6:       return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    task automatic send_sample(input int v, input bit tag);
        bus.Sample_i       = v[DW-1:0];
        bus.Temp_LDR_i     = tag;
        bus.Sample_valid_i = 1'b1;
        @(negedge clk);
        bus.Sample_valid_i = 1'b0;
    endtask

    // Entered "elapsed" negedges after the capture edge; returns on the
    // negedge where Frame_done_o is expected.
    task automatic collect_frame(input int v, input bit tag, input int elapsed,
                                 input int stall_idx, input int stall_len, input bit rand_ready);
        int lat = elapsed;
        int idx = 0;
        int stall_left = stall_len;
        int guard = 0;
        bit rdy;
        while (bus.Byte_valid_o !== 1'b1 && lat < 40) begin
            checks++;
            if (bus.Busy_o !== 1'b1 || bus.Byte_o !== 8'h00) begin
                errors++;
                $display("FAIL conv_state: busy=%b byte=%h required busy=1 byte=00", bus.Busy_o, bus.Byte_o);
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 14) begin
            errors++;
            $display("FAIL first_byte_latency: got %0d cycles required 14", lat);
        end
        while (idx < 8 && guard < 300) begin
            guard++;
            checks++;
            if (bus.Byte_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL valid_hold idx %0d: got %b required 1", idx, bus.Byte_valid_o);
            end
            checks++;
            if (bus.Byte_o !== exp_byte(v, tag, idx)) begin
                errors++;
                $display("FAIL byte idx %0d (v=%0d tag=%0d): got %h required %h", idx, v, tag, bus.Byte_o, exp_byte(v, tag, idx));
            end
            checks++;
            if (bus.Busy_o !== 1'b1 || bus.Frame_done_o !== 1'b0) begin
                errors++;
                $display("FAIL send_flags idx %0d: busy=%b done=%b required busy=1 done=0", idx, bus.Busy_o, bus.Frame_done_o);
            end
            if (idx == stall_idx && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            bus.Byte_ready_i = rdy;
            if (rdy) idx++;
            @(negedge clk);
        end
        bus.Byte_ready_i = 1'b1;
        checks++;
        if (bus.Frame_done_o !== 1'b1 || bus.Busy_o !== 1'b0 || bus.Byte_valid_o !== 1'b0 || bus.Byte_o !== 8'h00) begin
            errors++;
            $display("FAIL frame_end: done=%b busy=%b valid=%b byte=%h required 1 0 0 00",
                     bus.Frame_done_o, bus.Busy_o, bus.Byte_valid_o, bus.Byte_o);
        end
    endtask

    task automatic check_done_cleared(input string name);
        @(negedge clk);
        checks++;
        if (bus.Frame_done_o !== 1'b0 || bus.Byte_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: done=%b valid=%b required 0 0", name, bus.Frame_done_o, bus.Byte_valid_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.Busy_o !== 1'b0 || bus.Byte_valid_o !== 1'b0 || bus.Byte_o !== 8'h00 ||
            bus.Frame_done_o !== 1'b0 || bus.Overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b byte=%h done=%b ovr=%b required all 0",
                     bus.Busy_o, bus.Byte_valid_o, bus.Byte_o, bus.Frame_done_o, bus.Overrun_o);
        end
        rst = 1'b0;
        send_sample(2718, 1'b1);
        collect_frame(2718, 1'b1, 1, -1, 0, 1'b0);
        check_done_cleared("done_pulse_after_reset");
    endtask

    task automatic test_directed();
        int vals[3] = '{43, 4095, 0};
        bit tags[3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            send_sample(vals[i], tags[i]);
            collect_frame(vals[i], tags[i], 1, -1, 0, 1'b0);
            check_done_cleared("done_pulse_directed");
        end
    endtask

    task automatic test_stall();
        send_sample(43, 1'b0);
        collect_frame(43, 1'b0, 1, 4, 5, 1'b0);
        check_done_cleared("done_pulse_stall");
    endtask

    task automatic test_overrun();
        send_sample(1234, 1'b0);
        repeat (2) @(negedge clk);
        bus.Sample_i       = 12'd999;
        bus.Temp_LDR_i     = 1'b1;
        bus.Sample_valid_i = 1'b1;
        @(negedge clk);
        bus.Sample_valid_i = 1'b0;
        checks++;
        if (bus.Overrun_o !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse: got %b required 1", bus.Overrun_o);
        end
        @(negedge clk);
        checks++;
        if (bus.Overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL overrun_width: got %b required 0", bus.Overrun_o);
        end
        collect_frame(1234, 1'b0, 5, -1, 0, 1'b0);
        check_done_cleared("done_pulse_overrun");
    endtask

    task automatic test_back_to_back();
        send_sample(1000, 1'b1);
        collect_frame(1000, 1'b1, 1, -1, 0, 1'b0);
        send_sample(777, 1'b0);
        checks++;
        if (bus.Overrun_o !== 1'b0 || bus.Busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_capture: ovr=%b busy=%b required 0 1", bus.Overrun_o, bus.Busy_o);
        end
        collect_frame(777, 1'b0, 1, -1, 0, 1'b0);
        check_done_cleared("done_pulse_b2b");
    endtask

    task automatic test_reset_mid_frame();
        int g = 0;
        send_sample(2345, 1'b1);
        while (bus.Byte_valid_o !== 1'b1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        bus.Byte_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.Byte_o !== 8'h32 || bus.Byte_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_byte2: got %h valid=%b required 32 1", bus.Byte_o, bus.Byte_valid_o);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.Byte_valid_o !== 1'b0 || bus.Busy_o !== 1'b0 || bus.Byte_o !== 8'h00) begin
            errors++;
            $display("FAIL send_abort: valid=%b busy=%b byte=%h required 0 0 00", bus.Byte_valid_o, bus.Busy_o, bus.Byte_o);
        end
        for (int i = 0; i < 4; i++) check_done_cleared("send_abort_quiet");
        send_sample(506, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.Busy_o !== 1'b0) begin
            errors++;
            $display("FAIL conv_abort_busy: got %b required 0", bus.Busy_o);
        end
        for (int i = 0; i < 14; i++) check_done_cleared("conv_abort_quiet");
        send_sample(506, 1'b0);
        collect_frame(506, 1'b0, 1, -1, 0, 1'b0);
        check_done_cleared("done_pulse_after_abort");
    endtask

    task automatic test_random();
        int v;
        bit t;
        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(0, 4095));
            t = 1'($urandom_range(0, 1));
            send_sample(v, t);
            collect_frame(v, t, 1, -1, 0, 1'b1);
            check_done_cleared("done_pulse_random");
        end
    endtask

    initial begin
        bus.Sample_i       = '0;
        bus.Sample_valid_i = 1'b0;
        bus.Temp_LDR_i     = 1'b0;
        bus.Byte_ready_i   = 1'b1;
        test_reset();
        test_directed();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sample_ascii_fmt.md
SAMPLE_ASCII_FMT -- requirements
Module: sample_ascii_fmt

Interface
REQ-001 SHALL have parameter DATA_WIDTH_P, default 12, giving the ADC sample width; legal range 1..13, so the value always fits 4 decimal digits.
REQ-002 SHALL have port Clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port Reset_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have port Sample_i, input, DATA_WIDTH_P, the unsigned ADC sample from the SPI reader.
REQ-005 SHALL have port Sample_valid_i, input, 1, a one-cycle strobe marking Sample_i valid.
REQ-006 SHALL have port Temp_LDR_i, input, 1, the channel tag: 0 = temperature, 1 = LDR.
REQ-007 SHALL have port Busy_o, output, 1, high while a frame is being converted or sent.
REQ-008 SHALL have port Byte_o, output, 8, the ASCII byte offered to the UART transmitter.
REQ-009 SHALL have port Byte_valid_o, output, 1, high when Byte_o is offered.
REQ-010 SHALL have port Byte_ready_i, input, 1, high when the UART accepts a byte.
REQ-011 SHALL have port Frame_done_o, output, 1, a one-cycle pulse after the last byte transfers.
REQ-012 SHALL have port Overrun_o, output, 1, a one-cycle pulse when a sample strobe arrives while busy.

Function
REQ-013 SHALL implement FSM states IDLE, CONV and SEND, all registered.
REQ-014 In IDLE, on an edge with Sample_valid_i=1, SHALL capture Sample_i (zero-extended to 13 bits) and Temp_LDR_i, then enter CONV with the bit counter at 0.
REQ-015 In CONV, SHALL run binary-to-BCD conversion (double dabble), one shift per clock, for exactly 13 clocks, then enter SEND with byte index 0.
REQ-016 SHALL raise Byte_valid_o in the first cycle after the 13th CONV edge; capture-to-first-byte latency is 14 cycles.
REQ-017 SHALL emit the 8-byte frame in this order: prefix, ':', thousands, hundreds, tens, units, 0x0D, 0x0A.
REQ-018 The prefix byte SHALL be 0x54 ('T') when the captured tag is 0 and 0x4C ('L') when it is 1.
REQ-019 Each digit byte SHALL be 0x30 plus the BCD digit, with leading zeros always printed.
REQ-020 A transfer SHALL occur on each edge where Byte_valid_o=1 and Byte_ready_i=1; the byte index then advances by 1.
REQ-021 While Byte_valid_o=1 and Byte_ready_i=0, Byte_o SHALL hold stable and Byte_valid_o SHALL stay high.
REQ-022 Byte_valid_o SHALL NOT depend combinationally on Byte_ready_i.
REQ-023 On the transfer of byte index 7, SHALL enter IDLE, drop Byte_valid_o, and pulse Frame_done_o for exactly one cycle.
REQ-024 Busy_o SHALL be 1 in CONV and SEND and 0 in IDLE.
REQ-025 Busy_o SHALL already read 0 in the cycle of the Frame_done_o pulse.
REQ-026 A Sample_valid_i strobe in CONV or SEND SHALL be ignored and SHALL pulse Overrun_o one cycle later; captured data stays unchanged.
REQ-027 A Sample_valid_i strobe in the same cycle as the Frame_done_o pulse SHALL be captured, since the FSM is then in IDLE.
REQ-028 Byte_o SHALL read 0x00 whenever Byte_valid_o=0.

Reset
REQ-029 With Reset_i=1 on an edge, SHALL set state IDLE, Busy_o=0, Byte_valid_o=0, Byte_o=0x00, Frame_done_o=0, Overrun_o=0, and clear the counters and BCD register.
REQ-030 Reset asserted mid-CONV or mid-SEND SHALL abort the frame with no further bytes and no Frame_done_o pulse.
REQ-031 The first sample strobe one cycle after reset release SHALL be accepted.

Structure
REQ-032 The shared package SHALL hold: FSM state encoding, FRAME_LEN = 8, BCD_BITS = 13, ASCII constants 0x54, 0x4C, 0x3A, 0x30, 0x0D and 0x0A.
REQ-033 Conversion SHALL be a sub-module bin2bcd_seq (start, 13-bit binary in, done, 16-bit BCD out); sample_ascii_fmt owns the FSM and byte mux.

Verification
REQ-034 Sample 12'd43, tag 0, Byte_ready_i=1 -> bytes 54 3A 30 30 34 33 0D 0A on 8 consecutive edges, first byte 14 cycles after capture, then one Frame_done_o pulse.
REQ-035 Sample 12'd4095, tag 1 -> 4C 3A 34 30 39 35 0D 0A; sample 12'd0, tag 0 -> 54 3A 30 30 30 30 0D 0A.
REQ-036 Byte_ready_i held low for 5 cycles while byte index 4 (0x34) is offered -> Byte_o=0x34 and Byte_valid_o=1 held through all 5 cycles, no duplicate and no skipped byte.
REQ-037 Second strobe 3 cycles after capture (in CONV) -> one Overrun_o pulse, frame content unchanged; strobe coincident with Frame_done_o -> a new frame starts.
REQ-038 Reset_i pulsed during SEND at byte index 2 -> next cycle Byte_valid_o=0 and Busy_o=0, no Frame_done_o; the next sample yields a complete correct frame.
